fifo_salida: RTL and testbench

FIFO_SALIDA -- requirements
Module: fifo_salida

---
 rtl/fifo_salida_pkg.sv | 28 ++
 rtl/fifo_salida_memoria_fifo.sv | 52 +++++
 rtl/fifo_salida.sv | 128 ++++++++++++
 tb/tb_fifo_salida.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_salida_pkg.sv
// fifo_salida_pkg
// Shared defaults for the output FIFO that sits behind the 2:1 memory mux:
// data width, depth, almost-full / almost-empty thresholds and the pointer
// width derived from the depth. Also holds the flag bundle type and a small
// width helper used by both the FIFO top and its storage array.
package fifo_salida_pkg;

    localparam int FS_WIDTH     = 2;
    localparam int FS_DEPTH     = 4;
    localparam int FS_AF_THRESH = 3;
    localparam int FS_AE_THRESH = 1;

    // Bits needed to index 0..n-1 (ceil(log2(n))).
    function automatic int ptr_width(input int n);
        return $clog2(n);
    endfunction

    localparam int FS_PTR_W = ptr_width(FS_DEPTH);

    // Occupancy flags, all decoded from the registered count.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/fifo_salida_memoria_fifo.sv
// memoria_fifo
// Storage array for fifo_salida: one synchronous write port and one
// registered read port. The array itself is never reset; only the read
// register is cleared so data_out starts at zero.
// Ports:
//   clk        - clock, rising edge
//   reset_L    - synchronous active-low reset (read register only)
//   wr_en_i    - write strobe
//   wr_addr_i  - write address
//   wr_data_i  - write data
//   rd_en_i    - read strobe; when low the read register holds its value
//   rd_addr_i  - read address
//   rd_data_o  - registered read data
module memoria_fifo
    import fifo_salida_pkg::*;
#(
    parameter int WIDTH  = FS_WIDTH,
    parameter int DEPTH  = FS_DEPTH,
    parameter int ADDR_W = FS_PTR_W
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Reads the pre-write contents, so a read and write to the same slot
    // in one cycle (full FIFO, push+pop) returns the older word.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_salida.sv
// fifo_salida
// Output FIFO placed downstream of the 2:1 memory mux. The mux data_out /
// valid_out drive data_in / valid_in here. Pointers, occupancy count, flags
// and the sticky overflow bit live in this module; storage is memoria_fifo.
//
// Handshake: a write is offered whenever valid_in=1 (there is no ready back
// to the mux). It is accepted if the FIFO is not full, or if a pop is
// accepted in the same cycle; otherwise the word is dropped and overflow
// latches until reset. A pop is accepted when pop=1 and the FIFO is not
// empty; the popped word appears on data_out with valid_out=1 exactly one
// cycle later. No bypass: a push into an empty FIFO is not poppable in the
// same cycle.
//
// Ports:
//   clk, reset_L              - clock and synchronous active-low reset
//   data_in, valid_in         - write data / write request
//   pop                       - read request
//   data_out, valid_out       - registered read data and its qualifier
//   full, empty               - occupancy == DEPTH / == 0
//   almost_full, almost_empty - occupancy >= AF_THRESH / <= AE_THRESH
//   overflow                  - sticky: a write was dropped
module fifo_salida
    import fifo_salida_pkg::*;
#(
    parameter int WIDTH     = FS_WIDTH,
    parameter int DEPTH     = FS_DEPTH,
    parameter int AF_THRESH = FS_AF_THRESH,
    parameter int AE_THRESH = FS_AE_THRESH
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = ptr_width(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] CNT_AE    = CNT_W'(AE_THRESH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;

    fifo_flags_t flags;
    logic        push_acc;
    logic        pop_acc;

    // Flags depend only on the registered count: no input-to-output path.
    always_comb begin
        flags              = '0;
        flags.full         = (count_q == CNT_DEPTH);
        flags.empty        = (count_q == '0);
        flags.almost_full  = (count_q >= CNT_AF);
        flags.almost_empty = (count_q <= CNT_AE);
    end

    always_comb begin
        pop_acc    = pop & ~flags.empty;
        // A full FIFO still takes a write when a word leaves in the same cycle.
        push_acc   = valid_in & (~flags.full | pop_acc);

        wr_ptr_d   = push_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop_acc  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        valid_d    = pop_acc;
        overflow_d = overflow_q | (valid_in & ~push_acc);

        count_d = count_q;
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    memoria_fifo #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_memoria_fifo (
        .clk       (clk),
        .reset_L   (reset_L),
        .wr_en_i   (push_acc & reset_L),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (data_in),
        .rd_en_i   (pop_acc & reset_L),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (data_out)
    );

    assign valid_out    = valid_q;
    assign overflow     = overflow_q;
    assign full         = flags.full;
    assign empty        = flags.empty;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;

endmodule

// File: tb/tb_fifo_salida.sv
// Directed bench for fifo_salida. Each accepted pop pushes its hand-computed
// word into exp_q; a monitor on the falling edge pops and compares whenever
// valid_out is high. Flags are checked directly after each step.
module tb_fifo_salida;

    logic       clk;
    logic       reset_L;
    logic [1:0] data_in;
    logic       valid_in;
    logic       pop;
    logic [1:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;

    int vectors;
    int miscompares;
    logic [1:0] exp_q[$];

    fifo_salida dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {full, empty, almost_full, almost_empty}
    task automatic check_flags(input string name, input logic [3:0] exp);
        check(name, {28'd0, full, empty, almost_full, almost_empty}, {28'd0, exp});
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset_L && valid_out) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got valid_out data %0h expected no output at %0t",
                         data_out, $time);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    miscompares++;
                    $display("FAIL sb_data: got %0h expected %0h at %0t", data_out, e, $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; applies one cycle and returns at the next
    // falling edge, when outputs reflect the rising edge in between.
    task automatic cycle(input logic v, input logic [1:0] d, input logic p);
        valid_in = v;
        data_in  = d;
        pop      = p;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        pop      = 1'b0;
    endtask

    task automatic do_push(input logic [1:0] d);
        cycle(1'b1, d, 1'b0);
    endtask

    // Pop with the word this pop must return.
    task automatic do_pop(input logic [1:0] e);
        exp_q.push_back(e);
        cycle(1'b0, 2'b00, 1'b1);
    endtask

    task automatic do_push_pop(input logic [1:0] d, input logic [1:0] e);
        exp_q.push_back(e);
        cycle(1'b1, d, 1'b1);
    endtask

    task automatic fill(input logic [1:0] a, b, c, d);
        do_push(a); do_push(b); do_push(c); do_push(d);
    endtask

    // ---------------- stimulus ----------------
    logic [1:0] wrap_exp [6];

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_L     = 1'b0;
        valid_in    = 1'b0;
        pop         = 1'b0;
        data_in     = 2'b00;

        // Reset held for two cycles.
        @(negedge clk);
        cycle(1'b0, 2'b00, 1'b0);
        cycle(1'b0, 2'b00, 1'b0);
        reset_L = 1'b1;
        check_flags("reset_flags", 4'b0101);
        check("reset_valid_out", {31'd0, valid_out}, 32'd0);
        check("reset_data_out", {30'd0, data_out}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);

        // Fill with 01,10,11,00.
        do_push(2'b01); check_flags("push1_flags", 4'b0001);
        do_push(2'b10); check_flags("push2_flags", 4'b0000);
        do_push(2'b11); check_flags("push3_flags", 4'b0010);
        do_push(2'b00); check_flags("push4_flags", 4'b1010);

        // Drain in order.
        do_pop(2'b01); check_flags("pop1_flags", 4'b0010);
        do_pop(2'b10); check_flags("pop2_flags", 4'b0000);
        do_pop(2'b11); check_flags("pop3_flags", 4'b0001);
        do_pop(2'b00); check_flags("pop4_flags", 4'b0101);
        cycle(1'b0, 2'b00, 1'b0);
        check("idle_valid_out", {31'd0, valid_out}, 32'd0);
        check("idle_data_hold", {30'd0, data_out}, 32'd0);

        // Overflow: write to a full FIFO is dropped, flag is sticky.
        fill(2'b01, 2'b10, 2'b11, 2'b00);
        check("pre_ovf_overflow", {31'd0, overflow}, 32'd0);
        do_push(2'b11);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check_flags("ovf_flags", 4'b1010);
        cycle(1'b0, 2'b00, 1'b0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        do_pop(2'b01); do_pop(2'b10); do_pop(2'b11); do_pop(2'b00);
        check_flags("ovf_drain_flags", 4'b0101);
        check("ovf_after_drain", {31'd0, overflow}, 32'd1);
        cycle(1'b0, 2'b00, 1'b0);
        check("ovf_drain_no_extra", {31'd0, valid_out}, 32'd0);

        // Full with simultaneous push 10 and pop for 6 cycles; pointers wrap.
        fill(2'b00, 2'b01, 2'b10, 2'b11);
        wrap_exp = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b10};
        for (int i = 0; i < 6; i++) begin
            do_push_pop(2'b10, wrap_exp[i]);
            check_flags($sformatf("wrap_full_%0d", i), 4'b1010);
        end
        do_pop(2'b10); do_pop(2'b10); do_pop(2'b10); do_pop(2'b10);
        check_flags("wrap_drain_flags", 4'b0101);
        cycle(1'b0, 2'b00, 1'b0);

        // Empty with push and pop together: push only, no bypass.
        cycle(1'b1, 2'b01, 1'b1);
        check("empty_pp_valid_out", {31'd0, valid_out}, 32'd0);
        check_flags("empty_pp_flags", 4'b0001);
        do_push(2'b10);
        do_push(2'b11);
        check_flags("count3_flags", 4'b0010);

        // Reset mid-stream with push and pop asserted: everything discarded.
        reset_L = 1'b0;
        cycle(1'b1, 2'b00, 1'b1);
        reset_L = 1'b1;
        check_flags("midreset_flags", 4'b0101);
        check("midreset_valid_out", {31'd0, valid_out}, 32'd0);
        check("midreset_overflow", {31'd0, overflow}, 32'd0);
        check("midreset_data_out", {30'd0, data_out}, 32'd0);

        // Pop while empty with no push: no effect, no error.
        cycle(1'b0, 2'b00, 1'b1);
        check("empty_pop_valid_out", {31'd0, valid_out}, 32'd0);
        check("empty_pop_overflow", {31'd0, overflow}, 32'd0);
        check_flags("empty_pop_flags", 4'b0101);

        // Stale words must not come back: push one, pop it, then pop again.
        do_push(2'b11);
        do_pop(2'b11);
        cycle(1'b0, 2'b00, 1'b1);
        check("stale_pop_valid_out", {31'd0, valid_out}, 32'd0);
        cycle(1'b0, 2'b00, 1'b0);

        check("sb_leftover", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
